// File: rtl/sub_sat_acc_16_bit.sv
// sub_sat_acc_16_bit: saturating frame accumulator for a 16-bit subtractor's results, with overflow-flag correction
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   difference handshake (sub, OvP, OvN)
//   clr                 synchronous frame abort
//   acc/out_valid/out_ready  frame result handshake
//   sat_cnt             saturation events this frame (saturates at 255)
//   err                 sticky flag: OvP and OvN were both seen on an accepted beat
module sub_sat_acc_16_bit #(
  parameter int N_SAMPLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] sub,
  input  logic               OvP,
  input  logic               OvN,
  input  logic               clr,
  output logic signed [15:0] acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic        [7:0]  sat_cnt,
  output logic               err
);
  typedef enum logic {ACC, DONE} state_e;
  state_e             state_q, state_d;
  logic signed [15:0] acc_q, acc_d, corr, clamped;
  logic        [7:0]  sat_cnt_q, sat_cnt_d, cnt_q, cnt_d;
  logic               err_q, err_d, accept, bad, hi, lo, last;
  logic        [16:0] sum;
  logic        [8:0]  sat_sum;
  always_comb begin
    accept    = (state_q == ACC) && in_valid;
    bad       = OvP & OvN;
    corr      = (OvP & ~OvN) ? 16'sh7fff : (OvN & ~OvP) ? 16'sh8000 : sub;
    sum       = {acc_q[15], acc_q} + {corr[15], corr};
    // 17-bit sign bit disagreeing with bit 15 means the 16-bit range was left
    hi        = ~sum[16] & sum[15];
    lo        = sum[16] & ~sum[15];
    clamped   = hi ? 16'sh7fff : lo ? 16'sh8000 : sum[15:0];
    sat_sum   = {1'b0, sat_cnt_q} + 9'(OvP | OvN) + 9'(hi | lo);
    last      = cnt_q == 8'(N_SAMPLES - 1);
    state_d   = state_q;
    acc_d     = acc_q;
    sat_cnt_d = sat_cnt_q;
    cnt_d     = cnt_q;
    err_d     = err_q | (accept & bad & ~clr);
    if (clr || (state_q == DONE && out_ready)) begin
      state_d   = ACC;
      acc_d     = '0;
      sat_cnt_d = '0;
      cnt_d     = '0;
    end else if (accept && !bad) begin
      acc_d     = clamped;
      sat_cnt_d = sat_sum[8] ? 8'hff : sat_sum[7:0];
      cnt_d     = cnt_q + 8'd1;
      state_d   = last ? DONE : ACC;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACC;
      acc_q     <= '0;
      sat_cnt_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sat_cnt_q <= sat_cnt_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end
  assign in_ready  = state_q == ACC;
  assign out_valid = state_q == DONE;
  assign acc       = acc_q;
  assign sat_cnt   = sat_cnt_q;
  assign err       = err_q;
endmodule

// File: tb/tb_sub_sat_acc_16_bit.sv
// tb_sub_sat_acc_16_bit: three frame sizes driven in parallel against an integer reference model
module tb_sub_sat_acc_16_bit;
  logic        clk = 0, rst_n = 0, in_valid = 0, ovp = 0, ovn = 0, clr = 0, out_ready = 0;
  logic [15:0] sub = '0;
  logic        rdy [3], vld [3], err_o [3];
  logic [15:0] acc_o [3];
  logic [7:0]  sat_o [3];
  int          checks = 0, failures = 0;
  int          nsm [3] = '{4, 2, 200};
  bit          m_done [3], m_err [3];
  int          m_acc [3], m_sat [3], m_cnt [3];
  always #5 clk = ~clk;
  sub_sat_acc_16_bit #(.N_SAMPLES(4)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .sub(sub), .OvP(ovp), .OvN(ovn), .clr(clr), .acc(acc_o[0]), .out_valid(vld[0]), .out_ready(out_ready),
    .sat_cnt(sat_o[0]), .err(err_o[0]));
  sub_sat_acc_16_bit #(.N_SAMPLES(2)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .sub(sub), .OvP(ovp), .OvN(ovn), .clr(clr), .acc(acc_o[1]), .out_valid(vld[1]), .out_ready(out_ready),
    .sat_cnt(sat_o[1]), .err(err_o[1]));
  sub_sat_acc_16_bit #(.N_SAMPLES(200)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .sub(sub), .OvP(ovp), .OvN(ovn), .clr(clr), .acc(acc_o[2]), .out_valid(vld[2]), .out_ready(out_ready),
    .sat_cnt(sat_o[2]), .err(err_o[2]));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic model(input int i);
    int corr, s, cl;
    if (!rst_n) begin
      m_done[i] = 0; m_acc[i] = 0; m_sat[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
    end else if (clr || (m_done[i] && out_ready)) begin
      m_done[i] = 0; m_acc[i] = 0; m_sat[i] = 0; m_cnt[i] = 0;
    end else if (!m_done[i] && in_valid) begin
      if (ovp && ovn) m_err[i] = 1;
      else begin
        corr = ovp ? 32767 : ovn ? -32768 : int'($signed(sub));
        s = m_acc[i] + corr;
        cl = (s > 32767 || s < -32768) ? 1 : 0;
        m_acc[i] = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
        m_sat[i] = m_sat[i] + ((ovp || ovn) ? 1 : 0) + cl;
        if (m_sat[i] > 255) m_sat[i] = 255;
        m_cnt[i]++;
        if (m_cnt[i] == nsm[i]) m_done[i] = 1;
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("in_ready%0d", i), int'(rdy[i]), int'(!m_done[i]));
      chk($sformatf("out_valid%0d", i), int'(vld[i]), int'(m_done[i]));
      chk($sformatf("acc%0d", i), $signed(acc_o[i]), m_acc[i]);
      chk($sformatf("sat_cnt%0d", i), int'(sat_o[i]), m_sat[i]);
      chk($sformatf("err%0d", i), int'(err_o[i]), int'(m_err[i]));
    end
  endtask
  task automatic drv(input bit v, input int s, input bit p, input bit n, input bit c, input bit r);
    in_valid = v; sub = 16'(s); ovp = p; ovn = n; clr = c; out_ready = r;
    step();
  endtask
  task automatic do_reset();
    rst_n = 0; clr = 1; in_valid = 1; out_ready = 1;
    step();
    rst_n = 1; clr = 0; in_valid = 0; out_ready = 0;
  endtask
  initial begin
    int r;
    do_reset();
    chk("rst_rdy", int'(rdy[0]), 1);
    chk("rst_vld", int'(vld[0]), 0);
    chk("rst_acc", $signed(acc_o[0]), 0);
    // four clean samples, downstream always ready
    drv(1, 1000, 0, 0, 0, 1);
    drv(1, 2000, 0, 0, 0, 1);
    drv(1, -500, 0, 0, 0, 1);
    drv(1, 300, 0, 0, 0, 1);
    chk("r030_vld", int'(vld[0]), 1);
    chk("r030_acc", $signed(acc_o[0]), 2800);
    chk("r030_sat", int'(sat_o[0]), 0);
    drv(0, 0, 0, 0, 0, 1);
    chk("r030_back", int'(vld[0]), 0);
    chk("r030_zero", $signed(acc_o[0]), 0);
    // negative overflow then small negative: clamp at -32768
    do_reset();
    drv(1, -32000 - 4000, 0, 1, 0, 0);
    drv(1, -100, 0, 0, 0, 0);
    chk("r031_acc", $signed(acc_o[1]), -32768);
    chk("r031_sat", int'(sat_o[1]), 2);
    // positive overflow then large positive: clamp at +32767
    do_reset();
    drv(1, 32000 + 4000, 1, 0, 0, 0);
    drv(1, 28000, 0, 0, 0, 0);
    chk("r032_acc", $signed(acc_o[1]), 32767);
    chk("r032_sat", int'(sat_o[1]), 2);
    // illegal both-flags beat is dropped, then two real samples
    do_reset();
    drv(1, -28000, 1, 1, 0, 0);
    chk("r033_err", int'(err_o[1]), 1);
    chk("r033_drop", $signed(acc_o[1]), 0);
    drv(1, -28000, 0, 0, 0, 0);
    drv(1, -28000, 0, 0, 0, 0);
    chk("r033_acc", $signed(acc_o[1]), -32768);
    chk("r033_sat", int'(sat_o[1]), 1);
    // hold in DONE with upstream still presenting, then abort
    for (int k = 0; k < 5; k++) begin
      drv(1, 1234, 0, 0, 0, 0);
      chk("r034_rdy", int'(rdy[1]), 0);
      chk("r034_hold", $signed(acc_o[1]), -32768);
    end
    drv(1, 1234, 0, 0, 1, 1);
    chk("r034_clr_vld", int'(vld[1]), 0);
    chk("r034_clr_acc", $signed(acc_o[1]), 0);
    chk("r034_err_kept", int'(err_o[1]), 1);
    // reset mid-frame discards the partial sum
    do_reset();
    drv(1, 500, 0, 0, 0, 0);
    drv(1, 500, 0, 0, 0, 0);
    drv(1, 500, 0, 0, 0, 0);
    do_reset();
    chk("r035_acc", $signed(acc_o[0]), 0);
    chk("r035_sat", int'(sat_o[0]), 0);
    for (int k = 0; k < 4; k++) drv(1, 10, 0, 0, 0, 0);
    chk("r035_vld", int'(vld[0]), 1);
    chk("r035_sum", $signed(acc_o[0]), 40);
    // long frame of positive overflows drives sat_cnt into its ceiling
    do_reset();
    for (int k = 0; k < 200; k++) drv(1, 0, 1, 0, 0, 0);
    chk("sat_ceiling", int'(sat_o[2]), 255);
    chk("sat_acc", $signed(acc_o[2]), 32767);
    chk("sat_vld", int'(vld[2]), 1);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 7);
      rst_n = $urandom_range(0, 63) != 0;
      clr = $urandom_range(0, 31) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 1) == 1;
      ovp = (r == 0 || r == 2);
      ovn = (r == 1 || r == 2);
      sub = 16'($urandom);
      step();
    end
    // overflow-heavy traffic with rare drains to exercise saturation across frames
    rst_n = 1; clr = 0;
    for (int k = 0; k < 800; k++) begin
      in_valid = 1;
      ovp = $urandom_range(0, 3) != 0;
      ovn = !ovp && $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 15) == 0;
      sub = 16'($urandom);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
